// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield engine.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY,
        WIN_L,
        WIN_R
    } tug_state_t;

    function automatic int unsigned center(input int unsigned n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/tug_press_detect.sv
// Single-key rising-edge detector: combinational rise for the FSM, registered one-cycle press pulse.
// prev resets high so a key held through reset must be released before it counts.
module tug_press_detect (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    input  logic clr_i,
    output logic rise_o,
    output logic press_o
);

    logic prev_q, prev_d;
    logic press_q, press_d;

    assign rise_o  = key_i & ~prev_q;
    assign press_o = press_q;

    always_comb begin
        prev_d  = clr_i ? 1'b1 : key_i;
        press_d = rise_o;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: moves one lit LED on key presses and declares the winner.
// Define TUG_AUTORESTART_EN to return to play RESTART_CYCLES cycles after a win.
module tug_field
    import tug_pkg::*;
#(
    parameter int unsigned N_LIGHTS       = 9,
    parameter int unsigned RESTART_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_l,
    input  logic                key_r,
    output logic [N_LIGHTS-1:0] leds,
    output logic                edge_l,
    output logic                edge_r,
    output logic                press_l,
    output logic                press_r,
    output logic                win_l,
    output logic                win_r
);

    localparam int unsigned PosW = $clog2(N_LIGHTS);
    localparam logic [PosW-1:0] PosMax = PosW'(N_LIGHTS - 1);
    localparam logic [PosW-1:0] PosCenter = PosW'(center(N_LIGHTS));
    localparam logic [N_LIGHTS-1:0] LedOne = N_LIGHTS'(1);
    localparam logic [N_LIGHTS-1:0] LedsReset = LedOne << PosCenter;

    if (N_LIGHTS < 3 || (N_LIGHTS % 2) == 0 || RESTART_CYCLES < 1) begin : g_param_check
        $error("tug_field: N_LIGHTS must be odd and >= 3, RESTART_CYCLES >= 1");
    end

    tug_state_t          state_q, state_d;
    logic [PosW-1:0]     pos_q, pos_d;
    logic [N_LIGHTS-1:0] leds_q, leds_d;
    logic                edge_l_q, edge_l_d;
    logic                edge_r_q, edge_r_d;
    logic                win_l_q, win_l_d;
    logic                win_r_q, win_r_d;
    logic                rise_l, rise_r;
    logic                restart;

`ifdef TUG_AUTORESTART_EN
    localparam int unsigned CntW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(RESTART_CYCLES - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    tug_press_detect u_press_l (
        .clk     (clk),
        .reset   (reset),
        .key_i   (key_l),
        .clr_i   (restart),
        .rise_o  (rise_l),
        .press_o (press_l)
    );

    tug_press_detect u_press_r (
        .clk     (clk),
        .reset   (reset),
        .key_i   (key_r),
        .clr_i   (restart),
        .rise_o  (rise_r),
        .press_o (press_r)
    );

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        restart = 1'b0;
`ifdef TUG_AUTORESTART_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            PLAY: begin
                // Simultaneous rises cancel out.
                if (rise_l && !rise_r) begin
                    if (pos_q == PosMax) state_d = WIN_L;
                    else                 pos_d   = pos_q + 1'b1;
                end else if (rise_r && !rise_l) begin
                    if (pos_q == '0) state_d = WIN_R;
                    else             pos_d   = pos_q - 1'b1;
                end
            end
            WIN_L, WIN_R: begin
`ifdef TUG_AUTORESTART_EN
                if (cnt_q == '0) begin
                    restart = 1'b1;
                    state_d = PLAY;
                    pos_d   = PosCenter;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d = PLAY;
                pos_d   = PosCenter;
            end
        endcase
`ifdef TUG_AUTORESTART_EN
        if (state_q == PLAY && state_d != PLAY) cnt_d = CntLoad;
`endif
        // Outputs are registered from next state so win and LED clear share an edge.
        leds_d   = (state_d == PLAY) ? (LedOne << pos_d) : '0;
        edge_l_d = leds_d[N_LIGHTS-1];
        edge_r_d = leds_d[0];
        win_l_d  = (state_d == WIN_L);
        win_r_d  = (state_d == WIN_R);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= PLAY;
            pos_q    <= PosCenter;
            leds_q   <= LedsReset;
            edge_l_q <= 1'b0;
            edge_r_q <= 1'b0;
            win_l_q  <= 1'b0;
            win_r_q  <= 1'b0;
`ifdef TUG_AUTORESTART_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            leds_q   <= leds_d;
            edge_l_q <= edge_l_d;
            edge_r_q <= edge_r_d;
            win_l_q  <= win_l_d;
            win_r_q  <= win_r_d;
`ifdef TUG_AUTORESTART_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign leds   = leds_q;
    assign edge_l = edge_l_q;
    assign edge_r = edge_r_q;
    assign win_l  = win_l_q;
    assign win_r  = win_r_q;

endmodule

// File: tb/tb_tug_field.sv
// Scoreboard bench for tug_field: a behavioural model pushes expected outputs per driven cycle,
// a monitor pops and compares after each edge; scenario tasks add direct spot checks.
module tb_tug_field;

    localparam int N = 9;
    localparam int R = 4;
    localparam int C = 4;

    typedef struct packed {
        logic [N-1:0] leds;
        logic         edge_l;
        logic         edge_r;
        logic         press_l;
        logic         press_r;
        logic         win_l;
        logic         win_r;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         key_l = 1'b0;
    logic         key_r = 1'b0;
    logic [N-1:0] leds;
    logic         edge_l, edge_r, press_l, press_r, win_l, win_r;

    int n_total = 0;
    int n_pass  = 0;

    obs_t exp_q[$];

    int   m_state;
    int   m_pos;
    logic m_prev_l, m_prev_r;
    int   m_cnt;

    tug_field #(
        .N_LIGHTS       (N),
        .RESTART_CYCLES (R)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_l   (key_l),
        .key_r   (key_r),
        .leds    (leds),
        .edge_l  (edge_l),
        .edge_r  (edge_r),
        .press_l (press_l),
        .press_r (press_r),
        .win_l   (win_l),
        .win_r   (win_r)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, predict its outcome, return just after the rising edge.
    task automatic cyc(input logic kl, input logic kr, input logic rst);
        obs_t         e;
        logic         rl, rr;
        logic [N-1:0] one;
        one = 1;
        @(negedge clk);
        key_l = kl;
        key_r = kr;
        reset = rst;
        rl = 1'b0;
        rr = 1'b0;
        if (!rst) begin
            m_state  = 0;
            m_pos    = C;
            m_prev_l = 1'b1;
            m_prev_r = 1'b1;
            m_cnt    = 0;
        end else begin
            rl = kl & ~m_prev_l;
            rr = kr & ~m_prev_r;
            m_prev_l = kl;
            m_prev_r = kr;
            if (m_state == 0) begin
                if (rl && !rr) begin
                    if (m_pos == N - 1) begin m_state = 1; m_cnt = R - 1; end
                    else m_pos = m_pos + 1;
                end else if (rr && !rl) begin
                    if (m_pos == 0) begin m_state = 2; m_cnt = R - 1; end
                    else m_pos = m_pos - 1;
                end
            end else begin
`ifdef TUG_AUTORESTART_EN
                if (m_cnt == 0) begin
                    m_state  = 0;
                    m_pos    = C;
                    m_prev_l = 1'b1;
                    m_prev_r = 1'b1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
`endif
            end
        end
        e.leds    = (m_state == 0) ? (one << m_pos) : '0;
        e.edge_l  = e.leds[N-1];
        e.edge_r  = e.leds[0];
        e.press_l = rl;
        e.press_r = rr;
        e.win_l   = (m_state == 1);
        e.win_r   = (m_state == 2);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {leds, edge_l, edge_r, press_l, press_r, win_l, win_r};
                n_total++;
                if (a !== e)
                    $display("FAIL scoreboard t=%0t actual leds=%b el=%b er=%b pl=%b pr=%b wl=%b wr=%b required leds=%b el=%b er=%b pl=%b pr=%b wl=%b wr=%b",
                             $time, a.leds, a.edge_l, a.edge_r, a.press_l, a.press_r, a.win_l,
                             a.win_r, e.leds, e.edge_l, e.edge_r, e.press_l, e.press_r, e.win_l,
                             e.win_r);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        cyc(1'b0, 1'b0, 1'b0);
        n_total++;
        if (leds !== 9'b000010000) $display("FAIL reset_leds actual=%b required=%b", leds, 9'b000010000);
        else n_pass++;
        n_total++;
        if ({edge_l, edge_r, press_l, press_r, win_l, win_r} !== 6'b0)
            $display("FAIL reset_flags actual=%b required=%b",
                     {edge_l, edge_r, press_l, press_r, win_l, win_r}, 6'b0);
        else n_pass++;
    endtask

    task automatic test_hold_through_reset();
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            n_total++;
            if (press_l !== 1'b0 || leds !== 9'b000010000)
                $display("FAIL held_key actual press_l=%b leds=%b required press_l=0 leds=%b",
                         press_l, leds, 9'b000010000);
            else n_pass++;
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        n_total++;
        if (press_l !== 1'b1 || leds !== 9'b000100000)
            $display("FAIL first_press actual press_l=%b leds=%b required press_l=1 leds=%b",
                     press_l, leds, 9'b000100000);
        else n_pass++;
        cyc(1'b0, 1'b0, 1'b1);
        n_total++;
        if (press_l !== 1'b0) $display("FAIL pulse_width actual=%b required=0", press_l);
        else n_pass++;
    endtask

    task automatic test_walk_left_win();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        n_total++;
        if (edge_l !== 1'b1 || leds !== 9'b100000000)
            $display("FAIL left_edge actual edge_l=%b leds=%b required edge_l=1 leds=%b",
                     edge_l, leds, 9'b100000000);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b1);
        n_total++;
        if (win_l !== 1'b1 || leds !== 9'b0 || edge_l !== 1'b0)
            $display("FAIL left_win actual win_l=%b leds=%b edge_l=%b required win_l=1 leds=0 edge_l=0",
                     win_l, leds, edge_l);
        else n_pass++;
    endtask

    task automatic test_reset_in_win();
        cyc(1'b0, 1'b0, 1'b0);
        n_total++;
        if (leds !== 9'b000010000 || win_l !== 1'b0)
            $display("FAIL reset_in_win actual leds=%b win_l=%b required leds=%b win_l=0",
                     leds, win_l, 9'b000010000);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        n_total++;
        if (press_l !== 1'b1 || press_r !== 1'b1 || leds !== 9'b000010000)
            $display("FAIL simultaneous actual pl=%b pr=%b leds=%b required pl=1 pr=1 leds=%b",
                     press_l, press_r, leds, 9'b000010000);
        else n_pass++;
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_right_win_locked();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        n_total++;
        if (win_r !== 1'b1 || leds !== 9'b0)
            $display("FAIL right_win actual win_r=%b leds=%b required win_r=1 leds=0", win_r, leds);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            n_total++;
            if (press_l !== 1'b1 || leds !== 9'b0 || win_r !== 1'b1)
                $display("FAIL win_locked actual pl=%b leds=%b win_r=%b required pl=1 leds=0 win_r=1",
                         press_l, leds, win_r);
            else n_pass++;
            cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        n_total++;
        if (leds !== 9'b000100000) $display("FAIL b2b_first actual=%b required=%b", leds, 9'b000100000);
        else n_pass++;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        n_total++;
        if (leds !== 9'b001000000) $display("FAIL b2b_second actual=%b required=%b", leds, 9'b001000000);
        else n_pass++;
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_restart();
        int hi;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            if (i < 4) cyc(1'b0, 1'b0, 1'b1);
        end
        hi = win_l ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (win_l) hi++;
            else break;
        end
`ifdef TUG_AUTORESTART_EN
        n_total++;
        if (hi !== R) $display("FAIL restart_len actual=%0d required=%0d", hi, R);
        else n_pass++;
        n_total++;
        if (leds !== 9'b000010000) $display("FAIL restart_leds actual=%b required=%b", leds, 9'b000010000);
        else n_pass++;
`else
        n_total++;
        if (hi !== 21) $display("FAIL win_terminal actual=%0d required=%0d", hi, 21);
        else n_pass++;
        n_total++;
        if (leds !== 9'b0) $display("FAIL win_terminal_leds actual=%b required=0", leds);
        else n_pass++;
`endif
    endtask

    initial begin : main
        test_reset();
        test_hold_through_reset();
        test_walk_left_win();
        test_reset_in_win();
        test_simultaneous();
        test_right_win_locked();
        test_back_to_back();
        test_restart();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tug_field.md
# tug_field

Playfield engine for the two-player tug-of-war game. It converts the players' key levels into single-cycle press events and moves one lit LED along a row of N_LIGHTS. It drives the row and the two end-light flags, and declares the winner. It sits upstream of the victory/display logic, which consumes the end-light flags and the key presses.

## Interface
- N_LIGHTS, default 9: LEDs in the row. Must be odd and ≥ 3. Index N_LIGHTS-1 is the leftmost LED, index 0 the rightmost.
- RESTART_CYCLES, default 16: cycles held in a win state before auto-restart. Used only when TUG_AUTORESTART_EN is defined. Must be ≥ 1.

- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset. reset==0 at a posedge resets the block.
- key_l  in  1  left player key level, already synchronised to clk.
- key_r  in  1  right player key level, already synchronised to clk.
- leds  out  N_LIGHTS  playfield row; one-hot during play.
- edge_l  out  1  leftmost LED lit (leds[N_LIGHTS-1]).
- edge_r  out  1  rightmost LED lit (leds[0]).
- press_l  out  1  one-cycle left press pulse, registered.
- press_r  out  1  one-cycle right press pulse, registered.
- win_l  out  1  left player has won; level, held.
- win_r  out  1  right player has won; level, held.

## Operation
- CENTER = (N_LIGHTS-1)/2. The position register pos has width clog2(N_LIGHTS) and range 0..N_LIGHTS-1.
- Press detection, per key: prev register; rise = key & ~prev. prev resets to 1, so a key held through reset must be released before it counts. Holding a key yields exactly one press.
- States: PLAY, WIN_L, WIN_R.
- PLAY:
  - Left rise only, pos < N_LIGHTS-1: pos+1.
  - Right rise only, pos > 0: pos-1.
  - Both rise in the same cycle: no move and no win.
  - Left rise only, pos == N_LIGHTS-1: go to WIN_L.
  - Right rise only, pos == 0: go to WIN_R.
- WIN_L / WIN_R:
  - leds all 0, edge_l = edge_r = 0, and the matching win_* = 1.
  - Presses are still reported on press_*, but they never move pos.
  - Without the macro, the block stays in the win state until reset.
- leds = 1 << pos in PLAY; 0 otherwise. edge_l and edge_r are decoded from leds.
- Reset mid-game or mid-win: return immediately to PLAY with pos = CENTER.

## Timing
- Reset values:
  - pos = CENTER, leds = one-hot CENTER, state = PLAY.
  - edge_l = edge_r = 0 (for N_LIGHTS ≥ 3).
  - press_l = press_r = 0, win_l = win_r = 0.
  - prev_l = prev_r = 1, restart counter = 0.
- Latency: if a key is sampled high with prev = 0 at posedge t, press_* is high, and pos/leds/state show the move after posedge t. That is one cycle of latency and one-cycle-wide press pulses.
- Back-to-back: a key toggling 1,0,1 on consecutive cycles gives two moves, 2 cycles apart.
- The win_* outputs assert on the same edge that leds clears.

## Configuration
- TUG_AUTORESTART_EN defined:
  - A counter loads RESTART_CYCLES-1 on entry to WIN_L/WIN_R and decrements once per cycle.
  - At 0 the block returns to PLAY with pos = CENTER, so win_* is high for exactly RESTART_CYCLES cycles.
  - prev_l and prev_r are forced to 1 on restart.
- Not defined: no counter is present, and the win states are terminal until reset.

## Structure
- Package tug_pkg contains:
  - typedef enum logic [1:0] tug_state_t {PLAY, WIN_L, WIN_R}.
  - function center(n) returning (n-1)/2.
- Sub-module tug_press_detect: a single-key rising-edge detector with prev reset to 1 and a registered pulse output. It is instantiated twice.
- Top level contains: the FSM, the pos register, the LED decode, and the optional restart counter.

## Test plan
- Reset with key_l = 1 held, then keep the key held for 5 cycles → leds = 9'b000010000 throughout and press_l never pulses; release it and press again → leds = 9'b000100000.
- Five separate left presses from reset → pos steps 5,6,7,8. Before the fifth press: edge_l = 1, leds = 9'b100000000. After the fifth press: win_l = 1 and leds = 0.
- key_l and key_r rising in the same cycle → press_l = press_r = 1 and leds unchanged at CENTER.
- Five right presses → win_r = 1. Further left presses → press_l pulses but leds stays 0 and win_r stays 1.
- Reset asserted while in WIN_L → the next cycle shows leds = 9'b000010000 and win_l = 0.
- With TUG_AUTORESTART_EN and RESTART_CYCLES = 4 → win_l is high for exactly 4 cycles, then leds = 9'b000010000 and the block is in PLAY.
